regfile_scoreboard: RTL and testbench

//  Synthesizable end-of-run checker that consumes the processor's regfile write port and regfile read port A.

---
 rtl/regfile_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// End-of-run regfile checker: counts writes during a timed run, then
// scans every register through read port A against an expected-value ROM.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int CYC_W    = 14
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [CYC_W-1:0]  i_num_cycles,
    input  logic              i_rwe,
    input  logic [4:0]        i_rd,
    output logic              o_test_mode,
    output logic [4:0]        o_test_reg,
    input  logic [DATA_W-1:0] i_reg_value,
    output logic [4:0]        o_exp_addr,
    input  logic [DATA_W-1:0] i_exp_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [5:0]        o_error_count,
    output logic [15:0]       o_write_count,
    output logic [CYC_W-1:0]  o_cycle_count,
    output logic              o_fail_valid,
    output logic [4:0]        o_fail_reg,
    output logic [DATA_W-1:0] o_fail_exp,
    output logic [DATA_W-1:0] o_fail_act
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] LAST_IDX = 6'(NUM_REGS);

    logic [1:0]        r_state;
    logic [CYC_W-1:0]  r_num;
    logic [CYC_W-1:0]  r_cyc;
    logic [15:0]       r_wcnt;
    logic [5:0]        r_ecnt;
    logic              r_done;
    logic [5:0]        r_idx;
    logic [DATA_W-1:0] r_act_q;
    logic [4:0]        r_idx_q;
    logic              r_fail_valid;
    logic [4:0]        r_fail_reg;
    logic [DATA_W-1:0] r_fail_exp;
    logic [DATA_W-1:0] r_fail_act;

    logic w_start_ok;
    logic w_last_run;
    logic w_scan;
    logic w_scan_end;
    logic w_cmp;
    logic w_mis;

    assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_run = (r_cyc + CYC_W'(1)) == r_num;
    assign w_scan     = (r_state == S_SCAN);
    assign w_scan_end = w_scan && (r_idx == LAST_IDX);
    // The ROM answers one cycle after its address, so compare lags capture.
    assign w_cmp      = w_scan && (r_idx != 6'd0);
    assign w_mis      = w_cmp && (r_act_q != i_exp_data);

    // Phase sequencing: IDLE/DONE -> RUN (or straight to SCAN) -> SCAN -> DONE
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start)
                        r_state <= (i_num_cycles == '0) ? S_SCAN : S_RUN;
                end
                S_RUN: begin
                    if (w_last_run)
                        r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_scan_end)
                        r_state <= S_DONE;
                end
            endcase
        end
    end

    // Run-phase bookkeeping: cycle counter and saturating write counter
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_num  <= '0;
            r_cyc  <= '0;
            r_wcnt <= '0;
        end else if (w_start_ok) begin
            r_num  <= i_num_cycles;
            r_cyc  <= '0;
            r_wcnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cyc <= r_cyc + CYC_W'(1);
            if (i_rwe && i_rd != 5'd0 && r_wcnt != 16'hFFFF)
                r_wcnt <= r_wcnt + 16'd1;
        end
    end

    // Scan index and capture of the register value read this cycle
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_idx   <= '0;
            r_act_q <= '0;
            r_idx_q <= '0;
        end else if (w_scan) begin
            r_idx <= r_idx + 6'd1;
            if (r_idx < LAST_IDX) begin
                r_act_q <= i_reg_value;
                r_idx_q <= r_idx[4:0];
            end
        end else begin
            r_idx <= '0;
        end
    end

    // Mismatch accounting, first-failure capture and done flag
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ecnt       <= '0;
            r_done       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_reg   <= '0;
            r_fail_exp   <= '0;
            r_fail_act   <= '0;
        end else if (w_start_ok) begin
            r_ecnt       <= '0;
            r_done       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_reg   <= '0;
            r_fail_exp   <= '0;
            r_fail_act   <= '0;
        end else begin
            if (w_mis) begin
                r_ecnt <= r_ecnt + 6'd1;
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_reg   <= r_idx_q;
                    r_fail_exp   <= i_exp_data;
                    r_fail_act   <= r_act_q;
                end
            end
            if (w_scan_end)
                r_done <= 1'b1;
        end
    end

    assign o_test_mode   = w_scan;
    assign o_test_reg    = w_scan ? r_idx[4:0] : 5'd0;
    assign o_exp_addr    = w_scan ? r_idx[4:0] : 5'd0;
    assign o_busy        = (r_state == S_RUN) || w_scan;
    assign o_done        = r_done;
    assign o_pass        = r_done && (r_ecnt == 6'd0);
    assign o_error_count = r_ecnt;
    assign o_write_count = r_wcnt;
    assign o_cycle_count = r_cyc;
    assign o_fail_valid  = r_fail_valid;
    assign o_fail_reg    = r_fail_reg;
    assign o_fail_exp    = r_fail_exp;
    assign o_fail_act    = r_fail_act;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: regfile/ROM models, expected results
// queued at launch and checked when done rises.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] num;
    logic        rwe;
    logic [4:0]  rd;
    logic        test_mode;
    logic [4:0]  test_reg;
    logic [31:0] reg_value;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  error_count;
    logic [15:0] write_count;
    logic [13:0] cycle_count;
    logic        fail_valid;
    logic [4:0]  fail_reg;
    logic [31:0] fail_exp;
    logic [31:0] fail_act;

    logic [31:0] rf  [32];
    logic [31:0] rom [32];

    typedef struct {
        logic [15:0] wc;
        logic [5:0]  ec;
        logic        fv;
        logic [4:0]  fr;
        logic [31:0] fe;
        logic [31:0] fa;
        logic [13:0] cc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    regfile_scoreboard dut (
        .i_clock       (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_num_cycles  (num),
        .i_rwe         (rwe),
        .i_rd          (rd),
        .o_test_mode   (test_mode),
        .o_test_reg    (test_reg),
        .i_reg_value   (reg_value),
        .o_exp_addr    (exp_addr),
        .i_exp_data    (exp_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_pass        (pass),
        .o_error_count (error_count),
        .o_write_count (write_count),
        .o_cycle_count (cycle_count),
        .o_fail_valid  (fail_valid),
        .o_fail_reg    (fail_reg),
        .o_fail_exp    (fail_exp),
        .o_fail_act    (fail_act)
    );

    always #5 clk = ~clk;

    assign reg_value = rf[test_reg];

    always @(posedge clk) exp_data <= rom[exp_addr];

    // Pulse start, drive n RUN cycles (first nwr with rd=wrd, rest rd=0),
    // optionally poke start again at RUN cycle pk; push expected results.
    task automatic launch(input int n, input int nwr, input logic [4:0] wrd,
                          input int pk);
        exp_t e;
        e.wc = (wrd != 0) ? 16'((nwr < n) ? nwr : n) : 16'd0;
        e.ec = 0;
        e.fv = 0;
        e.fr = 0;
        e.fe = 0;
        e.fa = 0;
        e.cc = 14'(n);
        for (int r = 0; r < 32; r++) begin
            if (rom[r] !== rf[r]) begin
                if (!e.fv) begin
                    e.fv = 1;
                    e.fr = 5'(r);
                    e.fe = rom[r];
                    e.fa = rf[r];
                end
                e.ec = e.ec + 1;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        start = 1;
        num = 14'(n);
        @(negedge clk);
        start = 0;
        for (int i = 0; i < n; i++) begin
            rwe = 1;
            rd = (i < nwr) ? wrd : 5'd0;
            start = (i == pk);
            if (i == pk) num = 14'd3;
            @(negedge clk);
        end
        start = 0;
        rwe = 1;
        rd = wrd;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        rwe = 0;
        rd = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, pass, test_mode, fail_valid} !== 5'b0) begin
            $display("FAIL rst_flags: got %b want 00000",
                     {busy, done, pass, test_mode, fail_valid});
            bad++;
        end
        total++;
        if ({error_count, write_count, cycle_count, test_reg} !== '0) begin
            $display("FAIL rst_counts: got ec=%0d wc=%0d cc=%0d tr=%0d want 0",
                     error_count, write_count, cycle_count, test_reg);
            bad++;
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_match;
        bit ok;
        exp_t e;
        for (int r = 0; r < 32; r++) begin
            rf[r] = (r == 0) ? 32'd0 : $urandom;
            rom[r] = rf[r];
        end
        launch(10, 10, 5'd3, -1);
        wait_done(ok);
        total++;
        if (!ok) begin
            $display("FAIL match_timeout: done=%b want 1", done);
            bad++;
        end
        e = sb.pop_front();
        total++;
        if (pass !== 1'b1) begin
            $display("FAIL match_pass: got %b want 1", pass);
            bad++;
        end
        total++;
        if (write_count !== 16'd10 || write_count !== e.wc) begin
            $display("FAIL match_wc: got %0d want 10", write_count);
            bad++;
        end
        total++;
        if (error_count !== e.ec || fail_valid !== e.fv) begin
            $display("FAIL match_err: got ec=%0d fv=%b want ec=%0d fv=%b",
                     error_count, fail_valid, e.ec, e.fv);
            bad++;
        end
        total++;
        if (cycle_count !== e.cc || test_mode !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL match_state: got cc=%0d tm=%b busy=%b want cc=%0d 0 0",
                     cycle_count, test_mode, busy, e.cc);
            bad++;
        end
    endtask

    task automatic test_mismatch;
        bit ok;
        exp_t e;
        rom[5] = 32'd7;
        rf[5] = 32'd9;
        rom[20] = 32'd1;
        rf[20] = 32'd0;
        launch(4, 2, 5'd12, -1);
        wait_done(ok);
        total++;
        if (!ok) begin
            $display("FAIL mis_timeout: done=%b want 1", done);
            bad++;
        end
        e = sb.pop_front();
        total++;
        if (error_count !== 6'd2 || error_count !== e.ec) begin
            $display("FAIL mis_ec: got %0d want 2", error_count);
            bad++;
        end
        total++;
        if (fail_valid !== 1'b1 || fail_reg !== 5'd5 || fail_reg !== e.fr) begin
            $display("FAIL mis_reg: got fv=%b reg=%0d want 1 5",
                     fail_valid, fail_reg);
            bad++;
        end
        total++;
        if (fail_exp !== 32'd7 || fail_act !== 32'd9) begin
            $display("FAIL mis_vals: got exp=%0d act=%0d want 7 9",
                     fail_exp, fail_act);
            bad++;
        end
        total++;
        if (pass !== 1'b0 || write_count !== e.wc) begin
            $display("FAIL mis_pass_wc: got pass=%b wc=%0d want 0 %0d",
                     pass, write_count, e.wc);
            bad++;
        end
    endtask

    task automatic test_writes;
        bit ok;
        exp_t e;
        launch(10, 10, 5'd0, -1);
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || write_count !== 16'd0 || write_count !== e.wc) begin
            $display("FAIL wr_rd0: got ok=%b wc=%0d want 1 0", ok, write_count);
            bad++;
        end
        launch(10, 4, 5'd31, -1);
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || write_count !== 16'd4 || write_count !== e.wc) begin
            $display("FAIL wr_rd31: got ok=%b wc=%0d want 1 4", ok, write_count);
            bad++;
        end
        total++;
        if (error_count !== e.ec || fail_reg !== e.fr) begin
            $display("FAIL wr_err: got ec=%0d fr=%0d want %0d %0d",
                     error_count, fail_reg, e.ec, e.fr);
            bad++;
        end
    endtask

    task automatic test_zero_cycles;
        int k;
        exp_t e;
        launch(0, 0, 5'd7, -1);
        total++;
        if (test_mode !== 1'b1 || done !== 1'b0) begin
            $display("FAIL zero_tm: got tm=%b done=%b want 1 0", test_mode, done);
            bad++;
        end
        k = 1;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        rwe = 0;
        total++;
        if (k !== 34) begin
            $display("FAIL zero_lat: got done at %0d want 34", k);
            bad++;
        end
        e = sb.pop_front();
        total++;
        if (write_count !== e.wc || cycle_count !== e.cc || test_mode !== 1'b0) begin
            $display("FAIL zero_res: got wc=%0d cc=%0d tm=%b want %0d %0d 0",
                     write_count, cycle_count, test_mode, e.wc, e.cc);
            bad++;
        end
    endtask

    task automatic test_reset_scan;
        int k;
        bit ok;
        exp_t e;
        launch(5, 5, 5'd3, -1);
        k = 0;
        while (test_reg !== 5'd12 && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (test_reg !== 5'd12) begin
            $display("FAIL rs_reach: got tr=%0d want 12", test_reg);
            bad++;
        end
        reset = 1;
        @(negedge clk);
        sb.delete();
        total++;
        if ({test_mode, busy, done, pass, fail_valid} !== 5'b0 ||
            {error_count, write_count, cycle_count, test_reg} !== '0) begin
            $display("FAIL rs_clear: got tm=%b busy=%b ec=%0d wc=%0d cc=%0d want 0",
                     test_mode, busy, error_count, write_count, cycle_count);
            bad++;
        end
        reset = 0;
        rwe = 0;
        @(negedge clk);
        launch(8, 3, 5'd9, -1);
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || write_count !== e.wc || error_count !== e.ec ||
            fail_reg !== e.fr || fail_act !== e.fa || cycle_count !== e.cc) begin
            $display("FAIL rs_rerun: got wc=%0d ec=%0d fr=%0d cc=%0d want %0d %0d %0d %0d",
                     write_count, error_count, fail_reg, cycle_count,
                     e.wc, e.ec, e.fr, e.cc);
            bad++;
        end
    endtask

    task automatic test_start_ignore;
        bit ok;
        exp_t e;
        launch(20, 20, 5'd1, 5);
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || cycle_count !== 14'd20 || cycle_count !== e.cc) begin
            $display("FAIL si_cc: got cc=%0d want 20", cycle_count);
            bad++;
        end
        total++;
        if (write_count !== e.wc || error_count !== e.ec) begin
            $display("FAIL si_res: got wc=%0d ec=%0d want %0d %0d",
                     write_count, error_count, e.wc, e.ec);
            bad++;
        end
        rf[5] = 32'd7;
        launch(6, 6, 5'd4, -1);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || cycle_count !== 14'd6 ||
            error_count !== 6'd0 || fail_valid !== 1'b0) begin
            $display("FAIL sd_clear: got done=%b busy=%b cc=%0d ec=%0d fv=%b want 0 1 6 0 0",
                     done, busy, cycle_count, error_count, fail_valid);
            bad++;
        end
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || write_count !== e.wc || error_count !== e.ec ||
            fail_reg !== e.fr || fail_exp !== e.fe || fail_act !== e.fa) begin
            $display("FAIL sd_rerun: got wc=%0d ec=%0d fr=%0d want %0d %0d %0d",
                     write_count, error_count, fail_reg, e.wc, e.ec, e.fr);
            bad++;
        end
        total++;
        if (pass !== (e.ec == 0)) begin
            $display("FAIL sd_pass: got %b want %b", pass, e.ec == 0);
            bad++;
        end
    endtask

    initial begin
        clk = 0;
        reset = 1;
        start = 0;
        num = 0;
        rwe = 0;
        rd = 0;
        for (int r = 0; r < 32; r++) begin
            rf[r] = 0;
            rom[r] = 0;
        end
        test_reset();
        test_match();
        test_mismatch();
        test_writes();
        test_zero_cycles();
        test_reset_scan();
        test_start_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
